inst_fetch_queue: RTL
=====================

Name: inst_fetch_queue

Overview:
- Receiving end of the fetch-side PC/instruction stream: accepts each aligned (pc, inst) pair from the fetch alignment stage and buffers it in order.
- Presents entries to decode (ID) with a valid/ready handshake.
- Decouples ID stalls from fetch and drives a stall back to PC generation.
- Discards all buffered and in-flight entries on branch redirect or pipeline flush.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 4.
- ADDR_W, 32, PC width (matches InstAddrBus).
- INST_W, 32, instruction word width.
- SKID, 2, entries reserved for pushes already in flight when stall_o asserts; must be less than DEPTH.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- flush_i  input  1  pipeline flush; empty the queue
- branch_flag_i  input  1  branch redirect; same effect as flush_i
- pc_i  input  ADDR_W  PC of the incoming instruction
- pc_valid_i  input  1  pc_i/inst_i hold a valid pair this cycle
- inst_i  input  INST_W  instruction word matching pc_i
- id_ready_i  input  1  ID accepts the head entry this cycle
- id_valid_o  output  1  head entry valid
- id_pc_o  output  ADDR_W  head entry PC
- id_inst_o  output  INST_W  head entry instruction
- stall_o  output  1  request PC generation to hold
- count_o  output  log2(DEPTH)+1  current occupancy
- overflow_o  output  1  one-cycle pulse when a push is dropped

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset, read/write pointers = 0, count = 0, id_valid_o = 0, stall_o = 0, overflow_o = 0, id_pc_o = 0, id_inst_o = 0.
- Signal definitions:
  - kill = flush_i | branch_flag_i.
  - pop = id_valid_o & id_ready_i.
  - push_req = pc_valid_i & ~kill.
  - push = push_req & (count < DEPTH | pop).
- Priority: rst > kill > push/pop.
- Kill:
  - Next cycle: pointers = 0, count = 0, id_valid_o = 0.
  - Any push or pop presented in the kill cycle is ignored; ID must treat a handshake in that cycle as void.
  - overflow_o = 0 next cycle.
- Push: writes {pc_i, inst_i} at the write pointer, then the pointer increments modulo DEPTH.
  - No empty-queue bypass: a pair pushed in cycle N is first visible on id_*_o in cycle N+1.
- Pop: the read pointer increments modulo DEPTH.
  - id_pc_o/id_inst_o are read combinationally from the head slot.
  - Hold stable while id_valid_o = 1 and id_ready_i = 0.
- Count update:
  - +1 on push only; −1 on pop only; unchanged on both or neither.
  - Push and pop at count = DEPTH is legal; count stays DEPTH.
- Output decodes from registered state:
  - id_valid_o = (count != 0).
  - stall_o = (count >= DEPTH − SKID), from registered count; no input combinational paths.
- Full:
  - If push_req is high, count = DEPTH and pop = 0, the pair is dropped and overflow_o pulses high for exactly one cycle, the next cycle.
  - Queue contents are unchanged.
  - This is an upstream protocol violation; the queue never corrupts existing entries.
- Empty: pop cannot occur (id_valid_o = 0); id_pc_o/id_inst_o are don't-care.
- Ordering: strict FIFO across pointer wrap-around.
- Reset mid-operation behaves exactly like kill and additionally clears the outputs to 0.

Test Plan:
1. Reset then single push: rst high 2 cycles, release; push pc_i=0x1c000000, inst_i=0x02800c0c at cycle N with id_ready_i=0 -> id_valid_o=1 from N+1 with id_pc_o=0x1c000000, id_inst_o=0x02800c0c; count_o=1; stall_o=0.
2. Fill with ID blocked: id_ready_i=0; push PCs 0x1c000000+4k for k=0..8 on consecutive cycles -> stall_o=1 from the cycle count_o=6; count_o=8 after k=7; k=8 dropped with overflow_o=1 for one cycle; head still 0x1c000000.
3. Full with simultaneous push/pop: at count_o=8, push 0x1c000100 with id_ready_i=1 -> no overflow; count_o stays 8; head advances to 0x1c000004; 0x1c000100 is popped last.
4. Kill mid-stream: 5 entries queued, assert branch_flag_i for one cycle together with pc_valid_i=1 and id_ready_i=1 -> next cycle count_o=0, id_valid_o=0, stall_o=0; that cycle's pushed pair is never output. Repeat using flush_i, with identical result.
5. Wrap-around ordering: push 40 sequential PCs while toggling id_ready_i in a pseudo-random pattern, throttling pushes on stall_o with a 2-cycle in-flight model -> popped PCs strictly sequential; no overflow_o; no lost or duplicated entries.
6. Reset mid-operation: 4 entries queued, assert rst -> next cycle all outputs 0; a subsequent push reappears after one cycle of latency, as in scenario 1.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// In-order fetch queue between the fetch alignment stage and decode.
// Buffers (pc, inst) pairs, stalls PC generation early, and empties on kill.
module inst_fetch_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int SKID   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       branch_flag_i,
    input  logic [ADDR_W-1:0]          pc_i,
    input  logic                       pc_valid_i,
    input  logic [INST_W-1:0]          inst_i,
    input  logic                       id_ready_i,
    output logic                       id_valid_o,
    output logic [ADDR_W-1:0]          id_pc_o,
    output logic [INST_W-1:0]          id_inst_o,
    output logic                       stall_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]     wr_q, wr_d;
    logic [PW-1:0]     rd_q, rd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic kill;
    logic pop;
    logic push_req;
    logic push;
    logic full;

    assign kill     = flush_i | branch_flag_i;
    assign full     = (cnt_q == CW'(DEPTH));
    assign pop      = id_valid_o & id_ready_i;
    assign push_req = pc_valid_i & ~kill;
    assign push     = push_req & (~full | pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        if (kill) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                wr_d = wr_q + PW'(1);
            end
            if (pop) begin
                rd_d = rd_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
            // A dropped push leaves the stored entries untouched.
            ovf_d = push_req & full & ~pop;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_q]   <= pc_i;
            inst_mem[wr_q] <= inst_i;
        end
    end

    // Head data is masked when empty so reset and kill leave the outputs at zero.
    assign id_valid_o = (cnt_q != '0);
    assign id_pc_o    = id_valid_o ? pc_mem[rd_q] : '0;
    assign id_inst_o  = id_valid_o ? inst_mem[rd_q] : '0;
    assign stall_o    = (cnt_q >= CW'(DEPTH - SKID));
    assign count_o    = cnt_q;
    assign overflow_o = ovf_q;

endmodule
